// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
//
// Iterative radix-2 multiply/divide unit for the HI/LO operations. It sits
// beside the single-cycle ALU and returns a {hi, lo} pair for:
//   op 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
// Each request goes IDLE -> PREP -> CALC (WIDTH steps) -> FIX -> DONE.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   start_i      request valid; accepted when ready_o is high
//   ready_o      unit idle and able to accept a request
//   op_i         operation select (see above)
//   src0_i       multiplicand / dividend
//   src1_i       multiplier / divisor
//   flush_i      synchronous cancel of the operation in flight
//   out_valid_o  result valid
//   out_ready_i  consumer accepts the result
//   hi_o         product upper half / remainder
//   lo_o         product lower half / quotient
//   div_zero_o   result came from a divide with src1 == 0
//
// Optional build macro:
//   MULDIV_EARLY_OUT_EN  trivial multiplies (a zero operand) and divides
//                        with |dividend| < |divisor| skip CALC entirely.
// ---------------------------------------------------------------------------
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    output logic             ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src0_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    localparam int AW = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  src0_q, src0_d;
    logic [WIDTH-1:0]  src1_q, src1_d;
    // Multiplicand magnitude for multiplies, divisor magnitude for divides.
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    // Multiply: {carry, hi, lo}. Divide: {remainder[WIDTH:0], quotient}.
    logic [AW-1:0]     acc_q, acc_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              dz_q, dz_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              dzo_q, dzo_d;

    logic              is_div;
    logic              is_signed;
    logic [WIDTH-1:0]  mag0;
    logic [WIDTH-1:0]  mag1;
    logic              early;
    logic [WIDTH:0]    mul_upper;
    logic [AW-1:0]     mul_next;
    logic [WIDTH:0]    div_shift;
    logic              div_ge;
    logic [WIDTH:0]    div_rem;
    logic [AW-1:0]     div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]  quo_fix;
    logic [WIDTH-1:0]  rem_fix;

    assign is_div    = op_q[1];
    assign is_signed = op_q[0];

    // Operand magnitudes. The most negative value maps onto 2^(WIDTH-1),
    // which still fits as an unsigned WIDTH-bit number.
    always_comb begin
        mag0 = src0_q;
        mag1 = src1_q;
        if (is_signed && src0_q[WIDTH-1]) begin
            mag0 = (~src0_q) + WIDTH'(1);
        end
        if (is_signed && src1_q[WIDTH-1]) begin
            mag1 = (~src1_q) + WIDTH'(1);
        end
    end

    // Trivial-case detection used to bypass CALC. Divide-by-zero is never
    // trivial so that its raw-dividend/all-ones result path stays unique.
`ifdef MULDIV_EARLY_OUT_EN
    always_comb begin
        if (is_div) begin
            early = (mag1 != '0) && (mag0 < mag1);
        end else begin
            early = (mag0 == '0) || (mag1 == '0);
        end
    end
`else
    assign early = 1'b0;
`endif

    // One shift-add multiply step: add the multiplicand into the upper half
    // when the current multiplier bit is set, then shift right by one.
    always_comb begin
        if (acc_q[0]) begin
            mul_upper = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        end else begin
            mul_upper = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        end
        mul_next = {1'b0, mul_upper, acc_q[WIDTH-1:1]};
    end

    // One restoring divide step: shift the next dividend bit into the
    // remainder, subtract the divisor if it fits, and shift the quotient bit
    // in at the bottom. acc_q[AW-1] is the remainder's carry bit; if it is
    // ever set the shifted value certainly exceeds the divisor.
    always_comb begin
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = acc_q[AW-1] || (div_shift >= {1'b0, opnd_q});
        if (div_ge) begin
            div_rem = div_shift - {1'b0, opnd_q};
        end else begin
            div_rem = div_shift;
        end
        div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};
    end

    // Sign restoration applied in FIX.
    always_comb begin
        prod_fix = acc_q[2*WIDTH-1:0];
        quo_fix  = acc_q[WIDTH-1:0];
        rem_fix  = acc_q[2*WIDTH-1:WIDTH];
        if (qneg_q) begin
            prod_fix = (~acc_q[2*WIDTH-1:0]) + (2*WIDTH)'(1);
            quo_fix  = (~acc_q[WIDTH-1:0]) + WIDTH'(1);
        end
        if (rneg_q) begin
            rem_fix = (~acc_q[2*WIDTH-1:WIDTH]) + WIDTH'(1);
        end
    end

    // Next-state and datapath control. Flush wins over everything outside
    // IDLE and leaves the published result registers untouched.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src0_d  = src0_q;
        src1_d  = src1_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dzo_d   = dzo_q;

        if (flush_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_d    = op_i;
                        src0_d  = src0_i;
                        src1_d  = src1_i;
                        state_d = S_PREP;
                    end
                end
                S_PREP: begin
                    qneg_d = is_signed && (src0_q[WIDTH-1] ^ src1_q[WIDTH-1]);
                    rneg_d = is_signed && src0_q[WIDTH-1];
                    dz_d   = is_div && (src1_q == '0);
                    cnt_d  = '0;
                    if (is_div) begin
                        opnd_d = mag1;
                        acc_d  = {{(WIDTH+1){1'b0}}, mag0};
                    end else begin
                        opnd_d = mag0;
                        acc_d  = {{(WIDTH+1){1'b0}}, mag1};
                    end
                    if (early) begin
                        // Multiply result is zero; divide has quotient 0 and
                        // remainder equal to the dividend magnitude.
                        if (is_div) begin
                            acc_d = {1'b0, mag0, {WIDTH{1'b0}}};
                        end else begin
                            acc_d = '0;
                        end
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    acc_d = is_div ? div_next : mul_next;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (dz_q) begin
                        hi_d = src0_q;
                        lo_d = '1;
                    end else if (is_div) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    dzo_d   = dz_q;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset aborts any operation at once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            src0_q  <= '0;
            src1_q  <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src0_q  <= src0_d;
            src1_q  <= src1_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dzo_q   <= dzo_d;
        end
    end

    assign ready_o     = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign div_zero_o  = dzo_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Parametrised, iterative multiply/divide unit for the datapath's HI/LO operations.
- Handles signed and unsigned multiply and divide on WIDTH-bit operands, one radix-2 step per clock.
- Uses a start/ready request handshake and a valid/ready result handshake.
- Sits beside the single-cycle ALU and returns a {hi, lo} pair.

Parameters:
- WIDTH, 32: operand width in bits; must be >= 4.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  request valid.
- ready_o  out  1  unit idle, able to accept a request.
- op_i  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- src0_i  in  WIDTH  multiplicand / dividend.
- src1_i  in  WIDTH  multiplier / divisor.
- flush_i  in  1  synchronous cancel of the operation in flight.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- hi_o  out  WIDTH  product upper half / remainder.
- lo_o  out  WIDTH  product lower half / quotient.
- div_zero_o  out  1  result came from a divide with src1 == 0.

Behaviour:
- Reset: state IDLE, ready_o=1, out_valid_o=0, hi_o=0, lo_o=0, div_zero_o=0, counter=0, all internal registers 0.
  - Reset asserted mid-operation aborts immediately; no result is produced.
- Accept: a request is accepted on the edge where start_i && ready_o. op_i, src0_i and src1_i are captured on that edge. ready_o is high only in IDLE; start_i in any other state is ignored.
- States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
  - PREP (1 cycle):
    - Signed ops take the magnitudes of both operands.
    - Record the product/quotient sign as src0[MSB]^src1[MSB] and the remainder sign as src0[MSB].
    - Unsigned ops pass the operands through unchanged.
    - Detect divide-by-zero.
  - CALC (exactly WIDTH cycles, counter 0..WIDTH-1):
    - Multiply: shift-add over a 2*WIDTH+1 bit accumulator.
    - Divide: restoring shift-subtract; remainder is WIDTH+1 bits wide.
  - FIX (1 cycle):
    - Multiply: apply two's-complement negation to the 2*WIDTH product if the sign is negative.
    - Divide: negate the quotient per the quotient sign and the remainder per the remainder sign.
    - Load hi_o/lo_o.
  - DONE: out_valid_o=1; hi_o, lo_o and div_zero_o are held stable. On out_ready_i=1, go to IDLE and clear out_valid_o on that edge.
- Latency: out_valid_o rises in the cycle after edge E0+WIDTH+2, where E0 is the accept edge. This is 34 cycles for WIDTH=32, independent of the data.
- Divide by zero:
  - lo_o = all ones, hi_o = src0 as captured (raw), div_zero_o=1.
  - The full CALC sequence still runs, so latency is unchanged.
- Signed overflow, DIV of MIN by -1: lo_o=MIN, hi_o=0, no flag.
- Back-to-back: a new request can be accepted no earlier than the cycle after the DONE->IDLE edge.
- flush_i:
  - In PREP, CALC, FIX or DONE: go to IDLE on the next edge with out_valid_o=0. hi_o, lo_o and div_zero_o keep their last values.
  - In IDLE: no effect.
  - flush_i has priority over out_ready_i and over start_i.
- hi_o and lo_o change only on the FIX edge.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined, PREP checks for trivial cases and goes directly to FIX, skipping CALC:
  - Multiply with either magnitude zero: result 0.
  - Divide with nonzero divisor and dividend magnitude < divisor magnitude: quotient 0, remainder = dividend magnitude, then the normal sign fix.
- In those cases out_valid_o rises after edge E0+2.
- Divide-by-zero never takes the early path.
- When not defined, latency is always E0+WIDTH+2.

Test Plan:
1. WIDTH=32, MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001; out_valid_o exactly 34 cycles after accept; ready_o low throughout.
2. MULT -3 x 7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi_o=0x40000000, lo_o=0.
3. DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU 7/2 -> lo_o=3, hi_o=1. DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
4. DIVU 5/0 -> lo_o=0xFFFFFFFF, hi_o=5, div_zero_o=1. A following DIVU 9/3 -> div_zero_o=0, lo_o=3, hi_o=0.
5. Backpressure and flush:
   - Hold out_ready_i=0 for 5 cycles in DONE with start_i=1 -> outputs stable, ready_o=0, no new accept.
   - Separately, assert flush_i at counter=10 -> IDLE next edge, out_valid_o never rises, ready_o=1.
6. Reset and early out:
   - Drop rst_n_i mid-CALC -> ready_o=1, out_valid_o=0, hi_o=lo_o=0 immediately, before any clock edge.
   - With MULDIV_EARLY_OUT_EN, MULTU 0 x 0x1234 -> result 0 after E0+2. DIVU 3/8 -> lo_o=0, hi_o=3 after E0+2.
